// File: rtl/wave_seq_ctrl.sv
// wave_seq_ctrl
//   Serial waveform sequencer. A 16 x 8 pattern memory is played out one
//   bit per clock, LSB first. Playback covers words 0..len and repeats the
//   frame `loops` times (0 = until stop). It finishes with a one-cycle DONE
//   state.
//
// Ports
//   clk      in   single clock, rising edge
//   clear    in   asynchronous active-high reset (also reloads pattern memory)
//   start    in   level-sampled request to begin playback (IDLE/DONE only)
//   stop     in   level-sampled abort; wins over start
//   wr_en    in   pattern-memory write strobe (ignored while running)
//   wr_addr  in   [3:0] pattern-memory write address
//   wr_data  in   [7:0] pattern-memory write data
//   len      in   [3:0] index of last word in a frame (latched at start)
//   loops    in   [3:0] frame repeat count, 0 = endless (latched at start)
//   wave     out  registered serial waveform, IDLE_LEVEL when not running
//   busy     out  high while in RUN
//   done     out  one-cycle pulse on normal completion
//   addr     out  [3:0] word index being played
//   bit_idx  out  [2:0] bit position within the current word
module wave_seq_ctrl #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       start,
    input  logic       stop,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [3:0] len,
    input  logic [3:0] loops,
    output logic       wave,
    output logic       busy,
    output logic       done,
    output logic [3:0] addr,
    output logic [2:0] bit_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_reg, state_next;
    logic [3:0] addr_reg, addr_next;
    logic [2:0] bit_reg, bit_next;
    logic [3:0] len_reg, len_next;
    logic [3:0] loops_reg, loops_next;
    logic [3:0] loop_cnt_reg, loop_cnt_next;
    logic       wave_reg, wave_next;
    logic       more_frames;

    // Pattern memory. It has to be register-based because clear reloads
    // every word with the CC/AA pattern asynchronously.
    logic [7:0] mem_reg [16];
    logic       mem_we;

    assign mem_we = wr_en && (state_reg != RUN);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) begin
                mem_reg[i] <= i[0] ? 8'hAA : 8'hCC;
            end
        end else if (mem_we) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // The compare is done at 5 bits, so that loop_cnt+1 cannot wrap.
    assign more_frames = (loops_reg == 4'd0) ||
                         (({1'b0, loop_cnt_reg} + 5'd1) < {1'b0, loops_reg});

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        bit_next      = bit_reg;
        len_next      = len_reg;
        loops_next    = loops_reg;
        loop_cnt_next = loop_cnt_reg;
        wave_next     = wave_reg;

        case (state_reg)
            IDLE, DONE: begin
                state_next    = IDLE;
                addr_next     = 4'd0;
                bit_next      = 3'd0;
                loop_cnt_next = 4'd0;
                wave_next     = IDLE_LEVEL;
                if (start && !stop) begin
                    state_next = RUN;
                    len_next   = len;
                    loops_next = loops;
                    wave_next  = mem_reg[4'd0][0];
                end
            end
            RUN: begin
                if (stop) begin
                    state_next    = IDLE;
                    addr_next     = 4'd0;
                    bit_next      = 3'd0;
                    loop_cnt_next = 4'd0;
                    wave_next     = IDLE_LEVEL;
                end else begin
                    bit_next = bit_reg + 3'd1;
                    // addr only moves on the last bit, so a word is never split.
                    if (bit_reg == 3'd7) begin
                        if (addr_reg == len_reg) begin
                            addr_next = 4'd0;
                            if (more_frames) begin
                                loop_cnt_next = loop_cnt_reg + 4'd1;
                            end else begin
                                state_next    = DONE;
                                loop_cnt_next = 4'd0;
                            end
                        end else begin
                            addr_next = addr_reg + 4'd1;
                        end
                    end
                    // wave is registered from the position that becomes current.
                    wave_next = (state_next == DONE) ? IDLE_LEVEL
                                                     : mem_reg[addr_next][bit_next];
                end
            end
            default: begin
                state_next = IDLE;
                wave_next  = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_reg    <= IDLE;
            addr_reg     <= 4'd0;
            bit_reg      <= 3'd0;
            len_reg      <= 4'd0;
            loops_reg    <= 4'd0;
            loop_cnt_reg <= 4'd0;
            wave_reg     <= IDLE_LEVEL;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            bit_reg      <= bit_next;
            len_reg      <= len_next;
            loops_reg    <= loops_next;
            loop_cnt_reg <= loop_cnt_next;
            wave_reg     <= wave_next;
        end
    end

    assign wave    = wave_reg;
    assign busy    = (state_reg == RUN);
    assign done    = (state_reg == DONE);
    assign addr    = addr_reg;
    assign bit_idx = bit_reg;

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// tb_wave_seq_ctrl
//   Directed bench for wave_seq_ctrl. Expected per-cycle outputs
//   {wave,busy,done,addr,bit_idx} are pushed to a scoreboard queue as each
//   stimulus step is driven, then popped and compared 1 time unit after the
//   clock edge that produces them.
module tb_wave_seq_ctrl;

    localparam logic IL = 1'b1;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [7:0] wr_data = 8'd0;
    logic [3:0] len = 4'd0;
    logic [3:0] loops = 4'd0;
    logic       wave, busy, done;
    logic [3:0] addr;
    logic [2:0] bit_idx;

    wave_seq_ctrl #(.IDLE_LEVEL(IL)) dut (
        .clk(clk), .clear(clear), .start(start), .stop(stop),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .loops(loops),
        .wave(wave), .busy(busy), .done(done), .addr(addr), .bit_idx(bit_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       w;
        logic       b;
        logic       d;
        logic [3:0] a;
        logic [2:0] bi;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] tb_mem [16];
    int         checks = 0;
    int         errors = 0;

    function automatic exp_t mk(input logic w, input logic b, input logic d,
                                input logic [3:0] a, input logic [2:0] bi);
        exp_t e;
        e.w = w; e.b = b; e.d = d; e.a = a; e.bi = bi;
        return e;
    endfunction

    task automatic mem_model_reset();
        for (int i = 0; i < 16; i++) tb_mem[i] = i[0] ? 8'hAA : 8'hCC;
    endtask

    task automatic push_idle();
        sb.push_back(mk(IL, 1'b0, 1'b0, 4'd0, 3'd0));
    endtask

    task automatic compare(input string tag);
        exp_t e;
        exp_t got;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e   = sb.pop_front();
        got = {wave, busy, done, addr, bit_idx};
        assert (got === e) else begin
            errors++;
            $error("FAIL %s observed w=%b b=%b d=%b a=%0d bi=%0d expected w=%b b=%b d=%b a=%0d bi=%0d",
                   tag, got.w, got.b, got.d, got.a, got.bi, e.w, e.b, e.d, e.a, e.bi);
        end
        $display("t=%0t %s wave=%b busy=%b done=%b addr=%0d bit=%0d", $time, tag,
                 wave, busy, done, addr, bit_idx);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        push_idle();
        step("write");
        wr_en = 1'b0;
        tb_mem[a] = d;
    endtask

    // Plays one run. stop_k / clear_k (nonzero) abort at that RUN cycle;
    // restart re-asserts start in the DONE cycle. During every run the bench
    // tries a write of FF to word 0, pulses start again and scrambles
    // len/loops; none of that may change what is played.
    task automatic play(input string tag, input int l, input int lp,
                        input int stop_k, input int clear_k, input bit restart);
        int total;
        int w;
        int b;
        total   = (lp == 0) ? 2000 : 8 * (l + 1) * lp;
        len     = 4'(l);
        loops   = 4'(lp);
        wr_addr = 4'd0;
        wr_data = 8'hFF;
        for (int k = 0; k < total; k++) begin
            start = (k == 0) || (k == 3);
            wr_en = (k == 4);
            if (k == 2) begin
                len   = ~4'(l);
                loops = 4'(lp + 3);
            end
            if (stop_k != 0 && k == stop_k) begin
                stop = 1'b1;
                push_idle();
                step({tag, "_stop"});
                stop = 1'b0;
                push_idle();
                step({tag, "_after_stop"});
                return;
            end
            w = (k / 8) % (l + 1);
            b = k % 8;
            sb.push_back(mk(tb_mem[w][b], 1'b1, 1'b0, 4'(w), 3'(b)));
            step(tag);
            if (clear_k != 0 && k == clear_k) begin
                start = 1'b0;
                wr_en = 1'b0;
                #2 clear = 1'b1;
                #1;
                push_idle();
                compare({tag, "_clear"});
                @(negedge clk);
                clear = 1'b0;
                mem_model_reset();
                return;
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        sb.push_back(mk(IL, 1'b0, 1'b1, 4'd0, 3'd0));
        step({tag, "_done"});
        if (restart) begin
            start = 1'b1;
            len   = 4'(l);
            loops = 4'(lp);
            sb.push_back(mk(tb_mem[0][0], 1'b1, 1'b0, 4'd0, 3'd0));
            step({tag, "_restart"});
            start = 1'b0;
            stop  = 1'b1;
            push_idle();
            step({tag, "_restart_stop"});
            stop = 1'b0;
        end else begin
            push_idle();
            step({tag, "_idle"});
        end
    endtask

    initial begin
        mem_model_reset();
        #2 clear = 1'b1;
        #1;
        push_idle();
        compare("reset");
        @(negedge clk);
        clear = 1'b0;
        push_idle();
        step("post_reset");

        // One word, one frame: CC LSB first, done on the 9th cycle.
        play("single", 0, 1, 0, 0, 1'b0);

        // start and stop together in IDLE: nothing happens.
        start = 1'b1; stop = 1'b1;
        push_idle();
        step("start_stop");
        push_idle();
        step("start_stop2");
        start = 1'b0; stop = 1'b0;

        // Two words, two frames: CC,AA,CC,AA.
        play("two_by_two", 1, 2, 0, 0, 1'b0);

        // Back-to-back: start during the DONE cycle.
        play("restart", 0, 1, 0, 0, 1'b1);

        // IDLE write to word 0 is kept, the RUN-time write of FF is dropped.
        wr(4'd0, 8'h01);
        play("write_keep", 0, 2, 0, 0, 1'b0);

        // Endless playback, aborted at RUN cycle 20.
        play("endless_stop", 1, 0, 20, 0, 1'b0);

        // clear while playing addr 3 bit 4, then memory is back to CC/AA.
        play("clear_mid", 5, 1, 0, 28, 1'b0);
        play("after_clear", 1, 1, 0, 0, 1'b0);

        // Odd-address write and maximum loop count.
        wr(4'd3, 8'h5A);
        play("odd_word", 3, 1, 0, 0, 1'b0);
        play("loops15", 0, 15, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
